// File: rtl/burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : burst_scheduler
// Brief    : Round-robin write/read arbiter and sequencer for the DDR burst
//            engines, with engine timeout and per-direction completion counts.
// Revision : 1.0 - initial release
// ============================================================================
module burst_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         calib_done,
    input  logic         wr_req,
    input  logic [30:0]  wr_addr,
    input  logic [767:0] wr_data,
    output logic         wr_ack,
    output logic         wr_done,
    input  logic         rd_req,
    input  logic [30:0]  rd_addr,
    output logic         rd_ack,
    output logic         rd_valid,
    output logic [767:0] rd_data,
    output logic         wb_write,
    output logic [767:0] wb_data,
    output logic [30:0]  wb_address,
    input  logic         wb_busy,
    output logic         rb_read,
    output logic [30:0]  rb_address,
    input  logic         rb_busy,
    input  logic         rb_valid,
    input  logic [767:0] rb_data,
    output logic         busy,
    output logic         timeout_err,
    output logic [15:0]  wr_count,
    output logic [15:0]  rd_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_START = 3'd2,
        WR_WAIT  = 3'd3,
        RD_ISSUE = 3'd4,
        RD_START = 3'd5,
        RD_WAIT  = 3'd6
    } state_t;

    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic        r_last_wr;
    logic [15:0] r_tmo_cnt;

    logic [15:0] w_tmo_next;
    logic        w_tmo_hit;
    logic        w_grant_wr;
    logic        w_grant_rd;

    assign w_tmo_next = r_tmo_cnt + 16'd1;
    assign w_tmo_hit  = (w_tmo_next == c_tmo_last);
    // On contention the direction that did not win last time is served.
    assign w_grant_wr = calib_done && wr_req && !(rd_req && r_last_wr);
    assign w_grant_rd = calib_done && rd_req && !w_grant_wr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_last_wr   <= 1'b0;
            r_tmo_cnt   <= 16'd0;
            wr_ack      <= 1'b0;
            wr_done     <= 1'b0;
            rd_ack      <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            wb_write    <= 1'b0;
            wb_data     <= '0;
            wb_address  <= '0;
            rb_read     <= 1'b0;
            rb_address  <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            wr_count    <= 16'd0;
            rd_count    <= 16'd0;
        end else begin
            wr_ack      <= 1'b0;
            rd_ack      <= 1'b0;
            wb_write    <= 1'b0;
            rb_read     <= 1'b0;
            wr_done     <= 1'b0;
            rd_valid    <= 1'b0;
            timeout_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_grant_wr) begin
                        r_state    <= WR_ISSUE;
                        r_last_wr  <= 1'b1;
                        wb_address <= wr_addr;
                        wb_data    <= wr_data;
                        wr_ack     <= 1'b1;
                        wb_write   <= 1'b1;
                        busy       <= 1'b1;
                    end else if (w_grant_rd) begin
                        r_state    <= RD_ISSUE;
                        r_last_wr  <= 1'b0;
                        rb_address <= rd_addr;
                        rd_ack     <= 1'b1;
                        rb_read    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                WR_ISSUE: begin
                    r_state   <= WR_START;
                    r_tmo_cnt <= 16'd0;
                end

                WR_START, WR_WAIT: begin
                    if (r_state == WR_WAIT && !wb_busy) begin
                        r_state  <= IDLE;
                        busy     <= 1'b0;
                        wr_done  <= 1'b1;
                        wr_count <= wr_count + 16'd1;
                    end else if (w_tmo_hit) begin
                        r_state     <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        r_tmo_cnt <= w_tmo_next;
                        if (r_state == WR_START && wb_busy) begin
                            r_state <= WR_WAIT;
                        end
                    end
                end

                RD_ISSUE: begin
                    r_state   <= RD_START;
                    r_tmo_cnt <= 16'd0;
                end

                RD_START, RD_WAIT: begin
                    // Data is captured even on the edge that ends the transaction.
                    if (rb_valid) begin
                        rd_data  <= rb_data;
                        rd_valid <= 1'b1;
                    end
                    if (r_state == RD_WAIT && !rb_busy) begin
                        r_state  <= IDLE;
                        busy     <= 1'b0;
                        rd_count <= rd_count + 16'd1;
                    end else if (w_tmo_hit) begin
                        r_state     <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        r_tmo_cnt <= w_tmo_next;
                        if (r_state == RD_START && rb_busy) begin
                            r_state <= RD_WAIT;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_scheduler
// Brief    : Self-checking bench for burst_scheduler: transaction-level model,
//            emulated burst engines, directed scenarios and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_scheduler;

    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         calib_done;
    logic         wr_req;
    logic [30:0]  wr_addr;
    logic [767:0] wr_data;
    logic         wr_ack;
    logic         wr_done;
    logic         rd_req;
    logic [30:0]  rd_addr;
    logic         rd_ack;
    logic         rd_valid;
    logic [767:0] rd_data;
    logic         wb_write;
    logic [767:0] wb_data;
    logic [30:0]  wb_address;
    logic         wb_busy;
    logic         rb_read;
    logic [30:0]  rb_address;
    logic         rb_busy;
    logic         rb_valid;
    logic [767:0] rb_data;
    logic         busy;
    logic         timeout_err;
    logic [15:0]  wr_count;
    logic [15:0]  rd_count;

    burst_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .calib_done(calib_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wb_write(wb_write), .wb_data(wb_data), .wb_address(wb_address), .wb_busy(wb_busy),
        .rb_read(rb_read), .rb_address(rb_address), .rb_busy(rb_busy),
        .rb_valid(rb_valid), .rb_data(rb_data),
        .busy(busy), .timeout_err(timeout_err), .wr_count(wr_count), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Engine behaviour: 0 random, 1 six busy cycles, 2 stuck long past the timeout.
    int wr_mode = 1;
    int rd_mode = 1;
    bit rd_fixed = 1'b0;
    bit rand_clients = 1'b0;

    // Transaction-level model: direction in flight, age since start, engine engaged.
    int           m_dir = 0;
    int           m_age = 0;
    bit           m_eng = 1'b0;
    bit           m_last_wr = 1'b0;
    bit           m_bsy;
    logic         e_wr_ack = 0, e_rd_ack = 0, e_wb_write = 0, e_rb_read = 0;
    logic         e_wr_done = 0, e_rd_valid = 0, e_timeout = 0, e_busy = 0;
    logic [15:0]  e_wr_count = 0, e_rd_count = 0;
    logic [30:0]  e_wb_address = 0, e_rb_address = 0;
    logic [767:0] e_wb_data = 0, e_rd_data = 0;

    int n_ack, n_rack, n_start, n_done, n_valid, n_to, overlap, idle_run, max_idle, t0, t_to, k;
    logic [3:0] seq;

    function automatic logic [767:0] rand768();
        logic [767:0] r;
        for (int i = 0; i < 24; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_dir = 0; m_age = 0; m_eng = 0; m_last_wr = 0;
        e_wr_ack = 0; e_rd_ack = 0; e_wb_write = 0; e_rb_read = 0;
        e_wr_done = 0; e_rd_valid = 0; e_timeout = 0; e_busy = 0;
        e_wr_count = 0; e_rd_count = 0;
        e_wb_address = 0; e_rb_address = 0; e_wb_data = 0; e_rd_data = 0;
    endtask

    task automatic model_step();
        e_wr_ack = 0; e_rd_ack = 0; e_wb_write = 0; e_rb_read = 0;
        e_wr_done = 0; e_rd_valid = 0; e_timeout = 0;
        if (m_dir == 0) begin
            if (calib_done && wr_req && !(rd_req && m_last_wr)) begin
                m_dir = 1; m_last_wr = 1; m_age = -1; m_eng = 0;
                e_wr_ack = 1; e_wb_write = 1; e_wb_address = wr_addr; e_wb_data = wr_data;
            end else if (calib_done && rd_req) begin
                m_dir = 2; m_last_wr = 0; m_age = -1; m_eng = 0;
                e_rd_ack = 1; e_rb_read = 1; e_rb_address = rd_addr;
            end
        end else if (m_age < 0) begin
            m_age = 0;
        end else begin
            m_bsy = (m_dir == 1) ? wb_busy : rb_busy;
            if (m_dir == 2 && rb_valid) begin
                e_rd_valid = 1; e_rd_data = rb_data;
            end
            if (m_eng && !m_bsy) begin
                if (m_dir == 1) begin e_wr_done = 1; e_wr_count = e_wr_count + 16'd1; end
                else e_rd_count = e_rd_count + 16'd1;
                m_dir = 0;
            end else if (m_age + 1 == TMO - 1) begin
                e_timeout = 1; m_dir = 0;
            end else begin
                m_age++;
                if (m_bsy) m_eng = 1;
            end
        end
        e_busy = (m_dir != 0);
    endtask

    task automatic compare_all();
        chk("wr_ack", wr_ack, e_wr_ack);
        chk("rd_ack", rd_ack, e_rd_ack);
        chk("wb_write", wb_write, e_wb_write);
        chk("rb_read", rb_read, e_rb_read);
        chk("wr_done", wr_done, e_wr_done);
        chk("rd_valid", rd_valid, e_rd_valid);
        chk("timeout_err", timeout_err, e_timeout);
        chk("busy", busy, e_busy);
        chk("wr_count", wr_count, e_wr_count);
        chk("rd_count", rd_count, e_rd_count);
        chk("wb_address", wb_address, e_wb_address);
        chk("rb_address", rb_address, e_rb_address);
        chk("wb_data", wb_data, e_wb_data);
        chk("rd_data", rd_data, e_rd_data);
    endtask

    task automatic at_neg();
        @(negedge clk);
        cyc++;
        compare_all();
        if (rand_clients) begin
            if (wr_req && wr_ack) wr_req = 0;
            else if (!wr_req && $urandom_range(0, 3) == 0) begin
                wr_req = 1; wr_addr = 31'($urandom); wr_data = rand768();
            end
            if (rd_req && rd_ack) rd_req = 0;
            else if (!rd_req && $urandom_range(0, 3) == 0) begin
                rd_req = 1; rd_addr = 31'($urandom);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step(); else model_reset();
        at_neg();
    endtask

    task automatic do_reset();
        reset = 0;
        model_reset();
        tick(); tick();
        reset = 1;
    endtask

    task automatic wait_quiet(input string name);
        k = 0;
        while ((busy || wb_busy || rb_busy) && k < 200) begin tick(); k++; end
        chk(name, {busy, wb_busy, rb_busy}, 3'b000);
    endtask

    initial begin : wr_engine
        int d, n;
        wb_busy = 0;
        forever begin
            @(negedge clk);
            if (wb_write) begin
                d = (wr_mode == 0) ? int'($urandom_range(0, 2)) : 0;
                n = (wr_mode == 0) ? int'($urandom_range(1, 14)) : (wr_mode == 1 ? 6 : 40);
                repeat (d) @(negedge clk);
                wb_busy = 1;
                repeat (n) @(negedge clk);
                wb_busy = 0;
            end
        end
    end

    initial begin : rd_engine
        int d, n, v;
        rb_busy = 0; rb_valid = 0; rb_data = '0;
        forever begin
            @(negedge clk);
            rb_valid = 0;
            if (rb_read) begin
                d = (rd_mode == 0) ? int'($urandom_range(0, 2)) : 0;
                n = (rd_mode == 0) ? int'($urandom_range(2, 14)) : 6;
                v = int'($urandom_range(1, n - 1));
                repeat (d) @(negedge clk);
                rb_busy = 1;
                for (int i = 0; i < n; i++) begin
                    if (i == v) begin
                        rb_valid = 1;
                        rb_data  = rd_fixed ? 768'hA5 : rand768();
                    end
                    @(negedge clk);
                    rb_valid = 0;
                end
                rb_busy = 0;
            end else if (rd_mode == 0 && $urandom_range(0, 7) == 0) begin
                rb_valid = 1;
                rb_data  = rand768();
            end
        end
    end

    initial begin
        reset = 0; calib_done = 0; wr_req = 0; rd_req = 0;
        wr_addr = 0; wr_data = '0; rd_addr = 0;
        model_reset();
        tick(); tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_wr_count", wr_count, 16'd0);
        chk("reset_wb_data", wb_data, 768'd0);
        chk("reset_rd_data", rd_data, 768'd0);
        reset = 1;

        // Both requests pending while calibration is incomplete.
        wr_req = 1; rd_req = 1; wr_addr = 31'h10; wr_data = rand768(); rd_addr = 31'h20;
        n_ack = 0;
        repeat (50) begin tick(); if (wr_ack || rd_ack) n_ack++; end
        chk("calib_blocks_acks", n_ack, 0);
        calib_done = 1;
        tick();
        chk("calib_first_grant_wr", wr_ack, 1'b1);

        // Contention: both held high; acks must alternate starting with write.
        seq = 4'b0001; n_ack = 1; overlap = 0; idle_run = 0; max_idle = 0; k = 0;
        while (n_ack < 4 && k < 300) begin
            tick(); k++;
            if (wr_ack && rd_ack) overlap++;
            if (!busy) idle_run++;
            else begin if (idle_run > max_idle) max_idle = idle_run; idle_run = 0; end
            if (wr_ack || rd_ack) begin seq = {seq[2:0], wr_ack}; n_ack++; end
        end
        wr_req = 0; rd_req = 0;
        chk("contention_acks", n_ack, 4);
        chk("contention_order", seq, 4'b1010);
        chk("contention_overlap", overlap, 0);
        chk("contention_idle_gap", max_idle, 1);
        wait_quiet("contention_drain");

        // Single write on a fresh reset.
        do_reset();
        wr_mode = 1; wr_addr = 31'd1; wr_data = 768'd1; wr_req = 1;
        n_ack = 0; n_start = 0; n_done = 0;
        repeat (40) begin
            tick();
            if (wr_ack) begin n_ack++; wr_req = 0; end
            if (wb_write) n_start++;
            if (wr_done) n_done++;
        end
        chk("wr_single_ack", n_ack, 1);
        chk("wr_single_start", n_start, 1);
        chk("wr_single_done", n_done, 1);
        chk("wr_single_addr", wb_address, 31'd1);
        chk("wr_single_data", wb_data, 768'd1);
        chk("wr_single_count", wr_count, 16'd1);

        // Single read.
        rd_mode = 1; rd_fixed = 1; rd_addr = 31'h40; rd_req = 1;
        n_rack = 0; n_valid = 0;
        repeat (40) begin
            tick();
            if (rd_ack) begin n_rack++; rd_req = 0; end
            if (rd_valid) n_valid++;
        end
        chk("rd_single_ack", n_rack, 1);
        chk("rd_single_valid", n_valid, 1);
        chk("rd_single_data", rd_data, 768'hA5);
        chk("rd_single_addr", rb_address, 31'h40);
        chk("rd_single_rd_count", rd_count, 16'd1);
        chk("rd_single_wr_count", wr_count, 16'd1);

        // Timeout with the write engine stuck busy.
        wr_mode = 2; wr_req = 1; t0 = -1; t_to = -1; n_to = 0; n_done = 0;
        repeat (60) begin
            tick();
            if (wr_ack) begin t0 = cyc; wr_req = 0; end
            if (timeout_err) begin t_to = cyc; n_to++; end
            if (wr_done) n_done++;
        end
        chk("timeout_pulses", n_to, 1);
        chk("timeout_latency", t_to - t0, 16);
        chk("timeout_no_done", n_done, 0);
        chk("timeout_wr_count", wr_count, 16'd1);
        chk("timeout_idle", busy, 1'b0);
        wait_quiet("timeout_drain");

        // Asynchronous reset in the middle of a write.
        wr_mode = 1; wr_req = 1; k = 0;
        while (!wr_ack && k < 20) begin tick(); k++; end
        chk("rst_mid_grant", wr_ack, 1'b1);
        wr_req = 0;
        tick(); tick(); tick();
        @(posedge clk);
        model_step();
        #2;
        reset = 0;
        model_reset();
        #1;
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_wr_count", wr_count, 16'd0);
        chk("rst_async_rd_count", rd_count, 16'd0);
        chk("rst_async_wb_address", wb_address, 31'd0);
        chk("rst_async_wb_data", wb_data, 768'd0);
        chk("rst_async_rd_data", rd_data, 768'd0);
        at_neg();
        n_done = 0;
        repeat (3) begin tick(); if (wr_done) n_done++; end
        chk("rst_async_no_done", n_done, 0);
        reset = 1;
        wait_quiet("rst_engine_drain");
        wr_req = 1; n_ack = 0; n_done = 0;
        repeat (40) begin
            tick();
            if (wr_ack) begin n_ack++; wr_req = 0; end
            if (wr_done) n_done++;
        end
        chk("post_rst_ack", n_ack, 1);
        chk("post_rst_done", n_done, 1);
        chk("post_rst_wr_count", wr_count, 16'd1);

        // Random traffic against the model.
        wr_mode = 0; rd_mode = 0; rd_fixed = 0; rand_clients = 1;
        repeat (4000) begin
            tick();
            if ($urandom_range(0, 49) == 0) calib_done = !calib_done;
            if (cyc == 3000) do_reset();
        end
        rand_clients = 0; wr_req = 0; rd_req = 0; calib_done = 1;
        wait_quiet("final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
